add4simd_lane_packer: RTL and testbench

//   Upstream feeder/collector for the four-lane 12-bit SIMD adder (add4simd, "four12" DSP mode).
//   - Gathers scalar (a,b,tag) add requests from a valid/ready stream into four lanes.
//   - Presents the lanes to the SIMD adder as registered packed operands.
//   - Latches the four sums, then replays them as a scalar result stream in arrival order,

---
 rtl/add4simd_lane_packer.sv | 128 ++++++++++++
 tb/tb_add4simd_lane_packer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/add4simd_lane_packer.sv
// Lane packer for the four-lane 12-bit SIMD adder: gathers scalar add requests into four
// lanes, issues them as packed operands, then replays the sums with their tags in arrival order.
//
// state | meaning
// ------+-------------------------------------------------------------
// FILL  | accepting requests into lanes 0..3, timeout armed once a lane is used
// ISSUE | one cycle; packed operands stable, adder sums captured
// DRAIN | results replayed one lane per out_ready handshake
module add4simd_lane_packer #(
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [11:0]      in_a,
  input  logic [11:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic [47:0]      simd_a,
  output logic [47:0]      simd_b,
  input  logic [47:0]      simd_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [11:0]      out_sum,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_last
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {FILL, ISSUE, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [2:0]       cnt;
  logic [1:0]       rd;
  logic [TMR_W-1:0] tmr;
  logic [11:0]      a_q   [4];
  logic [11:0]      b_q   [4];
  logic [11:0]      r_q   [4];
  logic [TAG_W-1:0] tag_q [4];

  logic accept;
  logic last_rd;
  logic tmr_expired;

  assign in_ready    = (state == FILL);
  assign accept      = in_valid && in_ready;
  assign last_rd     = ({1'b0, rd} == (cnt - 3'd1));
  assign tmr_expired = (TIMEOUT != 0) && (cnt != 3'd0) && (tmr == '0);

  assign simd_a = {a_q[3], a_q[2], a_q[1], a_q[0]};
  assign simd_b = {b_q[3], b_q[2], b_q[1], b_q[0]};

  assign out_valid = (state == DRAIN);
  assign out_sum   = out_valid ? r_q[rd]   : '0;
  assign out_tag   = out_valid ? tag_q[rd] : '0;
  assign out_last  = out_valid && last_rd;

  always_comb begin
    state_nxt = state;
    case (state)
      FILL: begin
        // A request accepted alongside flush/timeout still joins the batch being issued.
        if ((accept && cnt == 3'd3) || (flush && (cnt != 3'd0 || accept)) || tmr_expired)
          state_nxt = ISSUE;
      end
      ISSUE:   state_nxt = DRAIN;
      DRAIN:   if (out_ready && last_rd) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= FILL;
      cnt   <= '0;
      rd    <= '0;
      tmr   <= '0;
      for (int k = 0; k < 4; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        r_q[k]   <= '0;
        tag_q[k] <= '0;
      end
    end else begin
      state <= state_nxt;
      case (state)
        FILL: begin
          if (accept) begin
            a_q[cnt[1:0]]   <= in_a;
            b_q[cnt[1:0]]   <= in_b;
            tag_q[cnt[1:0]] <= in_tag;
            cnt             <= cnt + 3'd1;
          end
          // Down-counter armed by the first lane; terminal count at zero triggers a partial issue.
          if (accept && cnt == 3'd0)
            tmr <= TMR_LOAD;
          else if (cnt != 3'd0 && tmr != '0)
            tmr <= tmr - 1'b1;
        end
        ISSUE: begin
          for (int k = 0; k < 4; k++)
            r_q[k] <= (3'(k) < cnt) ? simd_r[12*k +: 12] : 12'd0;
          rd <= '0;
        end
        DRAIN: begin
          if (out_ready) begin
            if (last_rd) begin
              cnt <= '0;
              rd  <= '0;
              for (int k = 0; k < 4; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
              end
            end else begin
              rd <= rd + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_add4simd_lane_packer.sv
// Directed bench for add4simd_lane_packer with a behavioural four-lane adder on simd_a/simd_b.
module tb_add4simd_lane_packer;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        in_valid, in_ready;
  logic [11:0] in_a, in_b;
  logic [3:0]  in_tag;
  logic        flush;
  logic [47:0] simd_a, simd_b, simd_r;
  logic        out_valid, out_ready;
  logic [11:0] out_sum;
  logic [3:0]  out_tag;
  logic        out_last;

  int total = 0;
  int bad   = 0;

  always #5 ap_clk = ~ap_clk;

  // External SIMD adder: independent 12-bit lanes, carries never cross lanes.
  always_comb begin
    simd_r = '0;
    for (int k = 0; k < 4; k++)
      simd_r[12*k +: 12] = simd_a[12*k +: 12] + simd_b[12*k +: 12];
  end

  add4simd_lane_packer #(.TAG_W(4), .TIMEOUT(16)) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_tag   (in_tag),
    .flush    (flush),
    .simd_a   (simd_a),
    .simd_b   (simd_b),
    .simd_r   (simd_r),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_tag  (out_tag),
    .out_last (out_last)
  );

  task automatic chk(input string nm, input logic [47:0] obs, input logic [47:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic send(input logic [11:0] a, input logic [11:0] b, input logic [3:0] t);
    int n = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_tag = t;
    while (!in_ready && n < 50) begin @(negedge ap_clk); n++; end
    if (n >= 50) chk("send_wait", {47'd0, in_ready}, 48'd1);
    @(negedge ap_clk);
    in_valid = 1'b0;
  endtask

  // Expects out_ready=1; checks the presented result then lets it be consumed.
  task automatic recv(input string nm, input logic [11:0] s, input logic [3:0] t, input logic l);
    int n = 0;
    while (!out_valid && n < 50) begin @(negedge ap_clk); n++; end
    chk({nm, "_valid"}, {47'd0, out_valid}, 48'd1);
    chk({nm, "_sum"},   {36'd0, out_sum},   {36'd0, s});
    chk({nm, "_tag"},   {44'd0, out_tag},   {44'd0, t});
    chk({nm, "_last"},  {47'd0, out_last},  {47'd0, l});
    chk({nm, "_inrdy"}, {47'd0, in_ready},  48'd0);
    @(negedge ap_clk);
  endtask

  logic [15:0] q[$];
  logic [15:0] e;
  logic [3:0]  tg;

  initial begin
    ap_rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    chk("rst_in_ready",  {47'd0, in_ready},  48'd1);
    chk("rst_out_valid", {47'd0, out_valid}, 48'd0);
    chk("rst_out_sum",   {36'd0, out_sum},   48'd0);
    chk("rst_out_tag",   {44'd0, out_tag},   48'd0);
    chk("rst_out_last",  {47'd0, out_last},  48'd0);
    chk("rst_simd_a",    simd_a, 48'd0);
    chk("rst_simd_b",    simd_b, 48'd0);

    // Full batch with wraparound lanes.
    out_ready = 1'b1;
    send(12'd1,   12'd2,   4'h1);
    send(12'h7FF, 12'd1,   4'h2);
    send(12'hFFF, 12'd1,   4'h3);
    send(12'd100, 12'd200, 4'h4);
    chk("full_issue_inrdy", {47'd0, in_ready},  48'd0);
    chk("full_issue_valid", {47'd0, out_valid}, 48'd0);
    chk("full_simd_a", simd_a, 48'h064_FFF_7FF_001);
    chk("full_simd_b", simd_b, 48'h0C8_001_001_002);
    @(negedge ap_clk);
    chk("full_latency_valid", {47'd0, out_valid}, 48'd1);
    recv("full0", 12'd3,   4'h1, 1'b0);
    recv("full1", 12'h800, 4'h2, 1'b0);
    recv("full2", 12'h000, 4'h3, 1'b0);
    recv("full3", 12'd300, 4'h4, 1'b1);
    chk("full_back_inrdy", {47'd0, in_ready}, 48'd1);
    chk("full_cleared_a",  simd_a, 48'd0);

    // Flush with no lanes filled does nothing.
    flush = 1'b1;
    repeat (3) @(negedge ap_clk);
    flush = 1'b0;
    chk("flush_empty_inrdy", {47'd0, in_ready},  48'd1);
    chk("flush_empty_valid", {47'd0, out_valid}, 48'd0);

    // Timeout: single request issues 16 cycles after its accept.
    send(12'd5, 12'd6, 4'h9);
    repeat (14) @(negedge ap_clk);
    chk("tmo_before_inrdy", {47'd0, in_ready}, 48'd1);
    @(negedge ap_clk);
    chk("tmo_edge_inrdy", {47'd0, in_ready}, 48'd1);
    @(negedge ap_clk);
    chk("tmo_issue_inrdy", {47'd0, in_ready},  48'd0);
    chk("tmo_issue_valid", {47'd0, out_valid}, 48'd0);
    @(negedge ap_clk);
    recv("tmo0", 12'd11, 4'h9, 1'b1);

    // Flush coinciding with an accept at cnt=2 issues a batch of three.
    send(12'd10, 12'd20, 4'h5);
    send(12'd30, 12'd40, 4'h6);
    in_valid = 1'b1; in_a = 12'd50; in_b = 12'd60; in_tag = 4'h7; flush = 1'b1;
    @(negedge ap_clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("fl_issue_inrdy", {47'd0, in_ready}, 48'd0);
    chk("fl_simd_a", simd_a, 48'h000_032_01E_00A);
    recv("fl0", 12'd30,  4'h5, 1'b0);
    recv("fl1", 12'd70,  4'h6, 1'b0);
    recv("fl2", 12'd110, 4'h7, 1'b1);

    // Backpressure: ten stalled cycles hold the first result steady.
    out_ready = 1'b0;
    send(12'd1, 12'd1, 4'h1);
    send(12'd2, 12'd2, 4'h2);
    send(12'd3, 12'd3, 4'h3);
    send(12'd4, 12'd4, 4'h4);
    @(negedge ap_clk);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", {47'd0, out_valid}, 48'd1);
      chk("bp_sum",   {36'd0, out_sum},   48'd2);
      chk("bp_tag",   {44'd0, out_tag},   48'd1);
      chk("bp_inrdy", {47'd0, in_ready},  48'd0);
      @(negedge ap_clk);
    end
    out_ready = 1'b1;
    recv("bp0", 12'd2, 4'h1, 1'b0);
    recv("bp1", 12'd4, 4'h2, 1'b0);
    recv("bp2", 12'd6, 4'h3, 1'b0);
    recv("bp3", 12'd8, 4'h4, 1'b1);

    // Reset in the middle of a drain.
    send(12'h010, 12'h001, 4'hA);
    send(12'h020, 12'h002, 4'hB);
    send(12'h030, 12'h003, 4'hC);
    send(12'h040, 12'h004, 4'hD);
    recv("mr0", 12'h011, 4'hA, 1'b0);
    recv("mr1", 12'h022, 4'hB, 1'b0);
    #2 ap_rst_n = 1'b0;
    #1;
    chk("mr_async_valid", {47'd0, out_valid}, 48'd0);
    chk("mr_async_sum",   {36'd0, out_sum},   48'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    chk("mr_rel_inrdy",  {47'd0, in_ready},  48'd1);
    chk("mr_rel_valid",  {47'd0, out_valid}, 48'd0);
    chk("mr_rel_simd_a", simd_a, 48'd0);
    send(12'd7, 12'd8, 4'hE);
    flush = 1'b1;
    @(negedge ap_clk);
    flush = 1'b0;
    chk("mr_fresh_issue", {47'd0, in_ready}, 48'd0);
    recv("mr_fresh", 12'd15, 4'hE, 1'b1);

    // Random stream against an in-order scoreboard.
    tg = 4'h0;
    for (int c = 0; c < 800; c++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_a      = 12'($urandom);
      in_b      = 12'($urandom);
      in_tag    = tg;
      flush     = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if (in_valid && in_ready) begin
        q.push_back({in_tag, 12'(in_a + in_b)});
        tg++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("rnd_underflow", 48'd1, 48'd0);
        else begin
          e = q.pop_front();
          chk("rnd_sum", {36'd0, out_sum}, {36'd0, e[11:0]});
          chk("rnd_tag", {44'd0, out_tag}, {44'd0, e[15:12]});
        end
      end
      @(negedge ap_clk);
    end
    in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (out_valid) begin
        if (q.size() == 0) chk("rnd_underflow", 48'd1, 48'd0);
        else begin
          e = q.pop_front();
          chk("rnd_sum", {36'd0, out_sum}, {36'd0, e[11:0]});
          chk("rnd_tag", {44'd0, out_tag}, {44'd0, e[15:12]});
        end
      end
      @(negedge ap_clk);
      if (q.size() == 0 && in_ready) break;
    end
    flush = 1'b0;
    chk("rnd_all_emitted", 48'(q.size()), 48'd0);
    chk("rnd_end_inrdy", {47'd0, in_ready}, 48'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
